// File: rtl/llfifo_sched_pkg.sv
// Shared widths, defaults and types for the linked-list FIFO scheduler.
package llfifo_sched_pkg;

  localparam int DEF_NUM_FIFOS = 2;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_QUOTA     = 3;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold a count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return safe_clog2(depth + 1);
  endfunction

  typedef logic [safe_clog2(DEF_NUM_FIFOS)-1:0] sel_t;
  typedef logic [cnt_width(DEF_DEPTH)-1:0]      cnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer wins, and the
// pointer moves to just past the winner. Without a grant the pointer holds.
module rr_arbiter
  import llfifo_sched_pkg::*;
#(
  parameter int N = 2,
  parameter int W = safe_clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [W-1:0] ptr;
  logic [W:0]   sum;
  logic [W-1:0] idx;
  logic [W:0]   nxt;

  // Scan upward from the pointer, wrapping at N-1, and take the first request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (W+1)'(off);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      idx = sum[W-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  // Pointer value one past the winner, modulo N.
  always_comb begin
    nxt = {1'b0, gnt_idx} + (W+1)'(1);
    if (nxt == (W+1)'(N)) nxt = '0;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst)      ptr <= '0;
    else if (any) ptr <= nxt[W-1:0];
  end

endmodule

// File: rtl/llfifo_scheduler.sv
// Round-robin push/pop scheduler with per-queue quota and occupancy
// bookkeeping cross-checked against the linked-list FIFO's flags.
module llfifo_scheduler
  import llfifo_sched_pkg::*;
#(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int QUOTA     = DEF_QUOTA,
  parameter int SEL_WIDTH = safe_clog2(NUM_FIFOS),
  parameter int CNT_WIDTH = cnt_width(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_FIFOS-1:0]           push_req,
  input  logic [NUM_FIFOS-1:0]           pop_req,
  input  logic                           ll_full,
  input  logic [NUM_FIFOS-1:0]           ll_empty,
  output logic                           push,
  output logic [SEL_WIDTH-1:0]           push_sel,
  output logic                           pop,
  output logic [SEL_WIDTH-1:0]           pop_sel,
  output logic [NUM_FIFOS-1:0]           push_gnt,
  output logic [NUM_FIFOS-1:0]           pop_gnt,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] occupancy,
  output logic [CNT_WIDTH-1:0]           total,
  output logic                           err
);

  logic [CNT_WIDTH-1:0] cnt [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] total_q;
  logic                 err_q;
  logic                 full_now;
  logic                 mismatch;
  logic [NUM_FIFOS-1:0] push_elig;
  logic [NUM_FIFOS-1:0] pop_elig;

  // Eligibility: quota and shared capacity gate pushes; only queues holding
  // entries may pop, so a queue cannot be popped in the cycle it is first pushed.
  always_comb begin
    push_elig = '0;
    pop_elig  = '0;
    full_now  = (total_q == CNT_WIDTH'(DEPTH));
    for (int i = 0; i < NUM_FIFOS; i++) begin
      push_elig[i] = !rst && push_req[i] && (cnt[i] < CNT_WIDTH'(QUOTA))
                     && !full_now && !ll_full;
      pop_elig[i]  = !rst && pop_req[i] && (cnt[i] != '0) && !ll_empty[i];
    end
  end

  rr_arbiter #(.N(NUM_FIFOS), .W(SEL_WIDTH)) u_push_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (push_elig),
    .gnt     (push_gnt),
    .gnt_idx (push_sel),
    .any     (push)
  );

  rr_arbiter #(.N(NUM_FIFOS), .W(SEL_WIDTH)) u_pop_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (pop_elig),
    .gnt     (pop_gnt),
    .gnt_idx (pop_sel),
    .any     (pop)
  );

  // Bookkeeping disagrees with the FIFO's own empty/full flags.
  always_comb begin
    mismatch = ((total_q == CNT_WIDTH'(DEPTH)) != ll_full);
    for (int i = 0; i < NUM_FIFOS; i++)
      mismatch = mismatch | ((cnt[i] == '0) != ll_empty[i]);
  end

  // Occupancy counters, total and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is tiny and must restart at zero with the FIFO, so it is reset like any flop.
      for (int i = 0; i < NUM_FIFOS; i++) cnt[i] <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        if (push_gnt[i] && !pop_gnt[i])      cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        else if (pop_gnt[i] && !push_gnt[i]) cnt[i] <= cnt[i] - CNT_WIDTH'(1);
      end
      if (push && !pop)      total_q <= total_q + CNT_WIDTH'(1);
      else if (pop && !push) total_q <= total_q - CNT_WIDTH'(1);
      err_q <= err_q | mismatch;
    end
  end

  // Flatten the per-queue counts.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_FIFOS; i++)
      occupancy[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end

  assign total = total_q;
  assign err   = err_q;

endmodule

// File: tb/tb_llfifo_scheduler.sv
// Randomised scoreboard bench for llfifo_scheduler. The driver models the
// queues as plain integer counts, emulates the FIFO's flags from them, and
// queues the expected outputs; the monitor compares on the falling edge.
module tb_llfifo_scheduler;
  import llfifo_sched_pkg::*;

  localparam int N  = DEF_NUM_FIFOS;
  localparam int D  = DEF_DEPTH;
  localparam int Q  = DEF_QUOTA;
  localparam int SW = safe_clog2(N);
  localparam int CW = cnt_width(D);

  logic            clk;
  logic            rst;
  logic [N-1:0]    push_req;
  logic [N-1:0]    pop_req;
  logic            ll_full;
  logic [N-1:0]    ll_empty;
  logic            push;
  logic [SW-1:0]   push_sel;
  logic            pop;
  logic [SW-1:0]   pop_sel;
  logic [N-1:0]    push_gnt;
  logic [N-1:0]    pop_gnt;
  logic [N*CW-1:0] occupancy;
  logic [CW-1:0]   total;
  logic            err;

  llfifo_scheduler #(.NUM_FIFOS(N), .DEPTH(D), .QUOTA(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_req  (push_req),
    .pop_req   (pop_req),
    .ll_full   (ll_full),
    .ll_empty  (ll_empty),
    .push      (push),
    .push_sel  (push_sel),
    .pop       (pop),
    .pop_sel   (pop_sel),
    .push_gnt  (push_gnt),
    .pop_gnt   (pop_gnt),
    .occupancy (occupancy),
    .total     (total),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]    push_gnt;
    logic [N-1:0]    pop_gnt;
    logic            push;
    logic            pop;
    sel_t            push_sel;
    sel_t            pop_sel;
    logic [N*CW-1:0] occ;
    cnt_t            total;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: entries held per queue, rr pointers, sticky error.
  int m_cnt [N];
  int m_total;
  int m_pptr;
  int m_qptr;
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("push_gnt",  32'(push_gnt),  32'(e.push_gnt));
        check("pop_gnt",   32'(pop_gnt),   32'(e.pop_gnt));
        check("push",      32'(push),      32'(e.push));
        check("pop",       32'(pop),       32'(e.pop));
        check("push_sel",  32'(push_sel),  32'(e.push_sel));
        check("pop_sel",   32'(pop_sel),   32'(e.pop_sel));
        check("occupancy", 32'(occupancy), 32'(e.occ));
        check("total",     32'(total),     32'(e.total));
        check("err",       32'(err),       32'(e.err));
      end
    end
  end

  // One cycle of stimulus: drive inputs, predict outputs, advance the model.
  task automatic step(input logic [N-1:0] pr, input logic [N-1:0] qr,
                      input logic r, input logic [N-1:0] empty_flip);
    exp_t e;
    int   pw, qw, i;
    bit   mm;
    push_req = pr;
    pop_req  = qr;
    rst      = r;
    ll_full  = (m_total == D);
    for (int k = 0; k < N; k++) ll_empty[k] = (m_cnt[k] == 0) ^ empty_flip[k];

    pw = -1;
    qw = -1;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        i = (m_pptr + k) % N;
        if (pw < 0 && pr[i] && m_cnt[i] < Q && m_total < D && !ll_full) pw = i;
        i = (m_qptr + k) % N;
        if (qw < 0 && qr[i] && m_cnt[i] != 0 && !ll_empty[i]) qw = i;
      end
    end

    e = '0;
    if (pw >= 0) begin
      e.push_gnt = N'(1) << pw;
      e.push     = 1'b1;
      e.push_sel = sel_t'(pw);
    end
    if (qw >= 0) begin
      e.pop_gnt = N'(1) << qw;
      e.pop     = 1'b1;
      e.pop_sel = sel_t'(qw);
    end
    for (int k = 0; k < N; k++) e.occ[k*CW +: CW] = CW'(m_cnt[k]);
    e.total = cnt_t'(m_total);
    e.err   = m_err;
    sb.push_back(e);

    mm = ((m_total == D) != ll_full);
    for (int k = 0; k < N; k++) if ((m_cnt[k] == 0) != ll_empty[k]) mm = 1'b1;

    @(posedge clk);
    if (r) begin
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      m_total = 0;
      m_pptr  = 0;
      m_qptr  = 0;
      m_err   = 1'b0;
    end else begin
      if (pw >= 0) begin
        m_cnt[pw]++;
        m_total++;
        m_pptr = (pw + 1) % N;
      end
      if (qw >= 0) begin
        m_cnt[qw]--;
        m_total--;
        m_qptr = (qw + 1) % N;
      end
      m_err = m_err | mm;
    end
    #1;
  endtask

  initial begin
    logic [N-1:0] flip;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_total = 0; m_pptr = 0; m_qptr = 0; m_err = 1'b0;

    // Unchecked first edge so the DUT's flops leave their power-up X state.
    rst = 1'b1; push_req = '0; pop_req = '0; ll_full = 1'b0; ll_empty = '1;
    @(posedge clk);
    #1;

    // Reset held with all requests high, then release: push to q0 only.
    step(2'b11, 2'b11, 1'b1, 2'b00);
    step(2'b11, 2'b11, 1'b1, 2'b00);
    step(2'b11, 2'b11, 1'b0, 2'b00);

    // Round-robin push: grants alternate 01, 10, 01.
    step(2'b00, 2'b00, 1'b1, 2'b00);
    repeat (3) step(2'b11, 2'b00, 1'b0, 2'b00);
    step(2'b00, 2'b00, 1'b0, 2'b00);

    // Quota on q0, then shared-full with a same-cycle pop.
    step(2'b00, 2'b00, 1'b1, 2'b00);
    repeat (4) step(2'b01, 2'b00, 1'b0, 2'b00);
    step(2'b10, 2'b00, 1'b0, 2'b00);
    step(2'b10, 2'b01, 1'b0, 2'b00);
    step(2'b00, 2'b00, 1'b0, 2'b00);

    // Simultaneous push and pop on the same queue, with and without entries.
    step(2'b00, 2'b00, 1'b1, 2'b00);
    step(2'b10, 2'b00, 1'b0, 2'b00);
    step(2'b10, 2'b10, 1'b0, 2'b00);
    step(2'b00, 2'b00, 1'b0, 2'b00);
    step(2'b00, 2'b00, 1'b1, 2'b00);
    step(2'b10, 2'b10, 1'b0, 2'b00);
    step(2'b00, 2'b00, 1'b0, 2'b00);

    // Flag disagreement sets err, which persists until reset.
    step(2'b00, 2'b00, 1'b1, 2'b00);
    step(2'b00, 2'b00, 1'b0, 2'b01);
    repeat (3) step(2'b01, 2'b01, 1'b0, 2'b00);
    step(2'b00, 2'b00, 1'b1, 2'b00);
    step(2'b00, 2'b00, 1'b0, 2'b00);

    // Random traffic with occasional resets and injected flag faults.
    for (int c = 0; c < 3000; c++) begin
      flip = ($urandom_range(0, 199) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
      step(N'($urandom), N'($urandom), ($urandom_range(0, 99) == 0), flip);
    end

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
